// File: rtl/bcd_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_ctrl
// Description : Keypad-loaded BCD mm:ss countdown timer with run/pause/done
//               control and a tick-timed alarm for the microwave controller.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_ctrl #(
    parameter int MIN_DIGITS  = 2,
    parameter int ALARM_TICKS = 3
) (
    input  logic                        clock,
    input  logic                        clrn,
    input  logic                        tick,
    input  logic [3:0]                  data,
    input  logic                        key_valid,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        cancel,
    output logic [4*(MIN_DIGITS+2)-1:0] digits,
    output logic                        zero,
    output logic [1:0]                  state,
    output logic                        running,
    output logic                        done_pulse,
    output logic                        alarm
);

    localparam int c_N  = MIN_DIGITS + 2;
    localparam int c_W  = 4 * c_N;
    localparam int c_AW = $clog2(ALARM_TICKS + 1);
    localparam logic [c_AW-1:0] c_ALARM = c_AW'(ALARM_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_W-1:0]   r_digits;
    logic [c_W-1:0]   w_digits_nxt;
    logic [c_W-1:0]   w_dec;
    logic [c_W-1:0]   w_shift;
    logic [c_N-1:0]   w_borrow;
    logic [c_AW-1:0]  r_acnt;
    logic [c_AW-1:0]  w_acnt_nxt;
    logic             r_done_pulse;
    logic             w_done_nxt;
    logic             w_zero;
    logic             w_dec_zero;
    logic             w_key_ok;

    // Mixed-radix borrow chain: sec tens wraps 0->5, every other digit 0->9.
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar i = 0; i < c_N; i++) begin : g_dec
            localparam logic [3:0] c_MAX = (i == 1) ? 4'd5 : 4'd9;
            assign w_dec[4*i +: 4] = !w_borrow[i] ? r_digits[4*i +: 4] :
                                     (r_digits[4*i +: 4] == 4'd0) ? c_MAX :
                                     r_digits[4*i +: 4] - 4'd1;
            if (i < c_N - 1) begin : g_borrow
                assign w_borrow[i+1] = w_borrow[i] && (r_digits[4*i +: 4] == 4'd0);
            end
        end
    endgenerate

    assign w_shift    = {r_digits[c_W-5:0], data};
    assign w_zero     = (r_digits == '0);
    assign w_dec_zero = (w_dec == '0);
    assign w_key_ok   = key_valid && (data <= 4'd9);

    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_acnt_nxt   = r_acnt;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cancel) begin
                    w_digits_nxt = '0;
                end else if (start) begin
                    if (!w_zero) w_state_nxt = S_RUN;
                end else if (stop) begin
                    w_digits_nxt = '0;
                end else if (w_key_ok) begin
                    w_digits_nxt = w_shift;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    w_state_nxt  = S_IDLE;
                    w_digits_nxt = '0;
                end else if (stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (tick && !w_zero) begin
                    w_digits_nxt = w_dec;
                    if (w_dec_zero) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_acnt_nxt  = c_ALARM;
                    end
                end
            end
            S_PAUSE: begin
                if (cancel) begin
                    w_state_nxt  = S_IDLE;
                    w_digits_nxt = '0;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end else if (stop) begin
                    w_state_nxt  = S_IDLE;
                    w_digits_nxt = '0;
                end
            end
            S_DONE: begin
                if (cancel || start || stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_key_ok) begin
                    w_digits_nxt = {{(c_W-4){1'b0}}, data};
                    w_state_nxt  = S_IDLE;
                end else if (tick) begin
                    w_acnt_nxt = r_acnt - c_AW'(1);
                    if (r_acnt <= c_AW'(1)) begin
                        w_acnt_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clrn) begin
            r_state      <= S_IDLE;
            r_digits     <= '0;
            r_acnt       <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_digits     <= w_digits_nxt;
            r_acnt       <= w_acnt_nxt;
            r_done_pulse <= w_done_nxt;
        end
    end

    assign digits     = r_digits;
    assign zero       = w_zero;
    assign state      = r_state;
    assign running    = (r_state == S_RUN);
    assign alarm      = (r_state == S_DONE);
    assign done_pulse = r_done_pulse;

endmodule
`default_nettype wire

// File: doc/bcd_countdown_ctrl.md
Name: bcd_countdown_ctrl

Overview:
- Parametrised next-generation countdown timer for the microwave controller.
- Combines keypad digit entry, a BCD mm:ss countdown with a configurable number of minute digits, and a run/pause/done state machine with a timed alarm.
- Sits between the keypad decoder (digit strobes, start/stop/cancel) and the 7-segment display driver.
- Counts on an external 1 Hz tick strobe.

Parameters:
- MIN_DIGITS, 2, number of BCD minute digits (≥1); total digits N = MIN_DIGITS+2.
- ALARM_TICKS, 3, ticks the alarm stays asserted in DONE before auto-return to IDLE (≥1).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clrn  in  1  synchronous active-low reset.
- tick  in  1  one-cycle 1 Hz count strobe.
- data  in  4  BCD key digit.
- key_valid  in  1  one-cycle strobe: data holds a new digit.
- start  in  1  one-cycle start/resume strobe.
- stop  in  1  one-cycle pause (from RUN) or clear (from PAUSE) strobe.
- cancel  in  1  one-cycle abort strobe.
- digits  out  4*N  BCD display value; [3:0]=sec ones, [7:4]=sec tens, [11:8]=min ones, upward.
- zero  out  1  high when every digit is 0 (combinational from digit registers).
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.
- running  out  1  state==RUN.
- done_pulse  out  1  one-cycle pulse on RUN->DONE.
- alarm  out  1  high while in DONE.

Behaviour:
- Reset (clrn=0 at clock edge): digits=0, state=IDLE, done_pulse=0, alarm=0, alarm counter=0. Reset overrides every other input, including mid-count.
- Command priority, same cycle: cancel > start > stop > key_valid > tick.
  - Only the highest-priority command acts.
  - tick is still processed in RUN if no higher-priority command changes state that cycle.
- Digit entry:
  - Accepted only in IDLE or DONE, and only when data ≤ 9; digits 10–15 are ignored.
  - IDLE: shift left one digit (sec ones <- data, each digit <- its lower neighbour, MSB discarded).
  - DONE: digits cleared, then data loaded into sec ones; state -> IDLE.
  - sec tens may hold 6–9 after entry. No normalisation: e.g. 1:90 counts 1:90, 1:89, ...
- IDLE:
  - start with zero=0 -> RUN, next cycle.
  - start with zero=1 -> ignored.
  - stop/cancel -> digits cleared.
- RUN, on tick:
  - Decrement as mixed-radix BCD.
  - sec ones: 0->9 with borrow.
  - sec tens: 0->5 with borrow, otherwise minus 1.
  - Each minute digit: 0->9 with borrow.
  - If the result is 0, then on the same edge: state -> DONE, done_pulse=1 for the following cycle only, alarm counter loaded with ALARM_TICKS.
  - Digits never wrap below 00:00.
- RUN commands:
  - stop -> PAUSE, digits frozen.
  - cancel -> IDLE, digits cleared.
  - start -> no effect.
  - key_valid -> ignored.
- PAUSE:
  - tick ignored.
  - start -> RUN.
  - stop or cancel -> IDLE, digits cleared.
- DONE:
  - alarm=1; digits read 0.
  - Each tick decrements the alarm counter; the tick that makes it reach 0 -> IDLE, alarm=0.
  - cancel, stop or start -> IDLE immediately.
  - key_valid behaves as in Digit entry.
- Latency:
  - All outputs except zero are registered; they change one cycle after the causing strobe is sampled.
  - zero follows digits in the same cycle.
- A tick coincident with start in IDLE does not decrement; counting begins on the next tick.

Test Plan:
- Reset mid-RUN at 01:23 -> next cycle digits=0, state=IDLE, alarm=0.
- key_valid with data 1,3,0, then data 12 -> digits=01:30, and data 12 leaves it unchanged.
- Countdown, MIN_DIGITS=2, from 01:00:
  - first tick -> 00:59 (borrow chain);
  - 59 further ticks -> 00:00;
  - state=DONE, done_pulse high exactly 1 cycle, alarm high for 3 ticks, then IDLE.
- RUN at 00:45:
  - stop -> PAUSE; 5 ticks leave 00:45;
  - start -> RUN; next tick -> 00:44;
  - stop twice -> IDLE, digits=0.
- Entry 1,9,0 -> 01:90; start; ticks -> 01:89, ..., 01:80, 01:79.
- Simultaneous cancel+start in RUN -> IDLE, digits 0.
- start with digits 0 -> stays IDLE.
- MIN_DIGITS=3, entry 9,9,9,5,9:
  - digits=999:59; 5th digit shifts out the MSB as specified.
  - One tick -> 999:58.
